button_debouncer: RTL and testbench



---
 rtl/gpu_io_pkg.sv | 17 +
 rtl/debounce_channel.sv | 68 ++++++
 rtl/button_debouncer.sv | 37 +++
 tb/tb_button_debouncer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/gpu_io_pkg.sv
// Shared constants and helpers for the GPU board I/O blocks.
// Timing is expressed in microseconds here and converted to clock cycles at elaboration.
package gpu_io_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned DEBOUNCE_US = 10_000;

    function automatic int unsigned us_to_cycles(input int unsigned us);
        return (CLK_HZ / 1_000_000) * us;
    endfunction

    // Counter width that can hold 0 .. cycles-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input bit: synchronizer chain, stability counter, state register
// and registered press/release strobes.
module debounce_channel
    import gpu_io_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic state_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned     CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   state_q, state_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   sync;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], din_i};
    assign sync   = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        cnt_d     = '0;
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync != state_q) begin
            if (cnt_q == LIMIT) begin
                state_d   = sync;
                press_d   = sync;
                release_d = ~sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Turns raw push-button/switch pins into clean synchronous levels and one-cycle
// press/release strobes; one independent debounce_channel per pin.
module button_debouncer
    import gpu_io_pkg::*;
#(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned STABLE_CYCLES = us_to_cycles(DEBOUNCE_US),
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_state,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    // Downstream logic always sees 1 = pressed, whatever the pin polarity.
    logic [N_BTN-1:0] btn_logical;
    assign btn_logical = btn_raw ^ {N_BTN{ACTIVE_LOW}};

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .din_i    (btn_logical[i]),
            .state_o  (btn_state[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: one active-high-pin instance and one active-low-pin instance,
// both with STABLE_CYCLES=8 and SYNC_STAGES=2, so changes land on edge 10.
module tb_button_debouncer;

    localparam int NEVER = 1000;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [3:0] raw_a, raw_b;
    logic [3:0] st_a, pr_a, rl_a;
    logic [3:0] st_b, pr_b, rl_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .N_BTN(4), .STABLE_CYCLES(8), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .btn_raw(raw_a),
        .btn_state(st_a), .btn_press(pr_a), .btn_release(rl_a)
    );

    button_debouncer #(
        .N_BTN(4), .STABLE_CYCLES(8), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .btn_raw(raw_b),
        .btn_state(st_b), .btn_press(pr_b), .btn_release(rl_b)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps edges first..last (numbered from the edge that first samples the new input)
    // and checks all three outputs of the chosen instance on each edge.
    task automatic watch(input string name, input bit use_b, input int first, input int last,
                         input int strobe_at, input logic [3:0] p_mask, input logic [3:0] r_mask,
                         input logic [3:0] st_before, input logic [3:0] st_after);
        for (int k = first; k <= last; k++) begin
            step();
            check($sformatf("%s state e%0d", name, k), use_b ? st_b : st_a,
                  (k >= strobe_at) ? st_after : st_before);
            check($sformatf("%s press e%0d", name, k), use_b ? pr_b : pr_a,
                  (k == strobe_at) ? p_mask : 4'b0000);
            check($sformatf("%s release e%0d", name, k), use_b ? rl_b : rl_a,
                  (k == strobe_at) ? r_mask : 4'b0000);
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        raw_a = 4'b1111;
        raw_b = 4'b1111;

        // Reset held with all A inputs pressed: everything stays at 0.
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("rst state e%0d", k), st_a, 4'b0000);
            check($sformatf("rst press e%0d", k), pr_a, 4'b0000);
            check($sformatf("rst release e%0d", k), rl_a, 4'b0000);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        watch("post_rst", 1'b0, 1, 12, 10, 4'b1111, 4'b0000, 4'b0000, 4'b1111);

        raw_a = 4'b0000;
        watch("all_rel", 1'b0, 1, 12, 10, 4'b0000, 4'b1111, 4'b1111, 4'b0000);

        // Seven-edge pulse is rejected.
        raw_a = 4'b0001;
        watch("glitch7_hi", 1'b0, 1, 7, NEVER, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        raw_a = 4'b0000;
        watch("glitch7_lo", 1'b0, 8, 13, NEVER, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Eight-edge pulse is accepted, then released nine edges after the input fell.
        raw_a = 4'b0001;
        watch("pulse8_hi", 1'b0, 1, 8, 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        raw_a = 4'b0000;
        watch("pulse8_press", 1'b0, 9, 12, 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        watch("pulse8_rel", 1'b0, 13, 20, 18, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

        // Clean press and release on bit 1.
        raw_a = 4'b0010;
        watch("clean_press", 1'b0, 1, 20, 10, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        raw_a = 4'b0000;
        watch("clean_rel", 1'b0, 1, 12, 10, 4'b0000, 4'b0010, 4'b0010, 4'b0000);

        // Bit 2 bounces every 3 edges for 30 edges, then settles high.
        for (int s = 0; s < 10; s++) begin
            raw_a = (s % 2 == 0) ? 4'b0100 : 4'b0000;
            watch($sformatf("bounce_s%0d", s), 1'b0, 3 * s + 1, 3 * s + 3, NEVER,
                  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        raw_a = 4'b0100;
        watch("bounce_settle", 1'b0, 1, 12, 10, 4'b0100, 4'b0000, 4'b0000, 4'b0100);

        // Bring bit 3 to a debounced 1, then bit 0 rises while bit 3 falls.
        raw_a = 4'b1100;
        watch("b3_press", 1'b0, 1, 12, 10, 4'b1000, 4'b0000, 4'b0100, 4'b1100);
        raw_a = 4'b0101;
        watch("simul", 1'b0, 1, 12, 10, 4'b0001, 4'b1000, 4'b1100, 4'b0101);

        // Active-low instance: press bit 0, reset mid-count on edge 5, full latency after.
        raw_b = 4'b1110;
        watch("al_count", 1'b1, 1, 4, NEVER, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst_b = 1'b1;
        watch("al_rst", 1'b1, 5, 5, NEVER, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst_b = 1'b0;
        watch("al_after", 1'b1, 1, 12, 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
